trail_stack: RTL

- Parametrised successor to the fixed 9-bit trace table used by the DPLL solver core.
- Holds the assignment trail as a LIFO: decisions (D) and forced/implied (F) assignments.
- Tracks the current decision level.
- On conflict, runs autonomous backtrack. Streams popped entries one per beat over a valid/ready handshake until the most recent decision has been popped. The downstream assignment memory unassigns each one, and the final decision is flipped by the decide unit.
- Reports unsatisfiability (done) when the backtrack reaches an empty trail with no decision.

---
 rtl/trail_stack.sv | 100 ++++++++++
 1 files changed

// File: rtl/trail_stack.sv
// trail_stack: DPLL assignment trail (LIFO of decision/forced entries) with autonomous streaming backtrack
// Ports:
//   clk, reset (sync, active-low)
//   push, t_type (0=D,1=F), val, variable      : append entry (IDLE only)
//   backtrack                                  : start backtrack pulse (IDLE only)
//   out_ready / out_valid                      : popped-entry beat handshake
//   type_out, val_out, variable_out, last      : beat contents, last = final beat of this backtrack
//   busy, empty, full, count, level            : status (level = decisions held)
//   overflow, done                             : sticky push-while-full / UNSAT flags
module trail_stack #(
   parameter int VAR_W = 9,
   parameter int DEPTH = 512,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             t_type,
   input  logic             val,
   input  logic [VAR_W-1:0] variable,
   input  logic             backtrack,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             type_out,
   output logic             val_out,
   output logic [VAR_W-1:0] variable_out,
   output logic             last,
   output logic             busy,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] level,
   output logic             overflow,
   output logic             done
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {S_IDLE, S_BT, S_DONE} state_t;
   state_t           r_state, w_next;
   logic [VAR_W+1:0] r_mem [DEPTH];
   logic [CNT_W-1:0] r_count, r_level, w_count, w_level, w_top_idx;
   logic             r_overflow, r_done, w_overflow, w_done, w_push_ok, w_top_d;
   logic [VAR_W+1:0] w_top;
   assign full         = r_count == CNT_W'(DEPTH);
   assign empty        = r_count == '0;
   assign count        = r_count;
   assign level        = r_level;
   assign overflow     = r_overflow;
   assign done         = r_done;
   assign w_top_idx    = r_count - CNT_W'(1);
   assign w_top        = r_mem[w_top_idx[AW-1:0]];
   assign w_top_d      = !w_top[VAR_W+1];
   assign busy         = r_state == S_BT;
   assign out_valid    = busy;
   // Data outputs are forced to zero outside BACKTRACK so an empty trail never exposes stale memory.
   assign type_out     = busy & w_top[VAR_W+1];
   assign val_out      = busy & w_top[VAR_W];
   assign variable_out = busy ? w_top[VAR_W-1:0] : '0;
   assign last         = busy && (w_top_d || r_count == CNT_W'(1));
   assign w_push_ok    = r_state == S_IDLE && push && !full;
   always_comb begin
      w_next     = r_state;
      w_count    = r_count;
      w_level    = r_level;
      w_overflow = r_overflow;
      w_done     = r_done;
      if (r_state == S_IDLE) begin
         // Push happens first; backtrack then sees the post-push count.
         w_count    = r_count + CNT_W'(w_push_ok);
         w_level    = r_level + CNT_W'(w_push_ok && !t_type);
         w_overflow = r_overflow | (push & full);
         if (backtrack) begin
            w_next = w_count != '0 ? S_BT : S_DONE;
            w_done = r_done | (w_count == '0);
         end
      end else if (r_state == S_BT && out_ready) begin
         w_count = w_top_idx;
         w_level = r_level - CNT_W'(w_top_d);
         w_next  = w_top_d ? S_IDLE : (r_count == CNT_W'(1) ? S_DONE : S_BT);
         w_done  = r_done | (!w_top_d && r_count == CNT_W'(1));
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_count    <= w_count;
         r_level    <= w_level;
         r_overflow <= w_overflow;
         r_done     <= w_done;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_count[AW-1:0]] <= {t_type, val, variable};
   end
endmodule
